// File: rtl/trace_commit_compactor_pkg.sv
// Shared trace-entry layout, FSM encoding and helpers for the commit
// trace compactor and any later trace-narrowing stage.
package trace_pkg;

    localparam int XLEN   = 64;
    localparam int INSN_W = 32;
    localparam int PRIV_W = 3;
    localparam int LCNT_W = 4;

    // Flat entry layout, LSB first; the capture stamp sits on top.
    localparam int OFF_HAS_WDATA = 0;
    localparam int OFF_INTERRUPT = 1;
    localparam int OFF_EXCEPTION = 2;
    localparam int OFF_VALID     = 3;
    localparam int OFF_PRIV      = 4;
    localparam int OFF_INSN      = OFF_PRIV + PRIV_W;
    localparam int OFF_WDATA     = OFF_INSN + INSN_W;
    localparam int OFF_CAUSE     = OFF_WDATA + XLEN;
    localparam int OFF_IADDR     = OFF_CAUSE + XLEN;
    localparam int OFF_STAMP     = OFF_IADDR + XLEN;
    localparam int TRACE_ENTRY_W = OFF_STAMP + XLEN;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    function automatic logic [15:0] sat_add16(
        input logic [15:0]       a,
        input logic [LCNT_W-1:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/trace_commit_compactor_if.sv
// Core-side wide commit trace in, two-lane cosim trace out.
interface trace_commit_compactor_if #(
    parameter int IN_LANES = 4
);
    import trace_pkg::*;

    logic [XLEN-1:0]            cycle;
    logic [IN_LANES-1:0]        in_valid;
    logic [IN_LANES-1:0]        in_exception;
    logic [IN_LANES-1:0]        in_interrupt;
    logic [IN_LANES-1:0]        in_has_wdata;
    logic [XLEN*IN_LANES-1:0]   in_iaddr;
    logic [XLEN*IN_LANES-1:0]   in_cause;
    logic [XLEN*IN_LANES-1:0]   in_wdata;
    logic [INSN_W*IN_LANES-1:0] in_insn;
    logic [PRIV_W*IN_LANES-1:0] in_priv;

    logic [XLEN-1:0]   out_cycle;
    logic              trace_0_valid;
    logic              trace_0_exception;
    logic              trace_0_interrupt;
    logic              trace_0_has_wdata;
    logic [XLEN-1:0]   trace_0_iaddr;
    logic [XLEN-1:0]   trace_0_cause;
    logic [XLEN-1:0]   trace_0_wdata;
    logic [INSN_W-1:0] trace_0_insn;
    logic [PRIV_W-1:0] trace_0_priv;
    logic              trace_1_valid;
    logic              trace_1_exception;
    logic              trace_1_interrupt;
    logic              trace_1_has_wdata;
    logic [XLEN-1:0]   trace_1_iaddr;
    logic [XLEN-1:0]   trace_1_cause;
    logic [XLEN-1:0]   trace_1_wdata;
    logic [INSN_W-1:0] trace_1_insn;
    logic [PRIV_W-1:0] trace_1_priv;
    logic              overflow;
    logic [15:0]       drop_count;
    logic              empty;

    modport master (
        output cycle, in_valid, in_exception, in_interrupt, in_has_wdata,
        output in_iaddr, in_cause, in_wdata, in_insn, in_priv,
        input  out_cycle,
        input  trace_0_valid, trace_0_exception, trace_0_interrupt,
        input  trace_0_has_wdata, trace_0_iaddr, trace_0_cause,
        input  trace_0_wdata, trace_0_insn, trace_0_priv,
        input  trace_1_valid, trace_1_exception, trace_1_interrupt,
        input  trace_1_has_wdata, trace_1_iaddr, trace_1_cause,
        input  trace_1_wdata, trace_1_insn, trace_1_priv,
        input  overflow, drop_count, empty
    );

    modport slave (
        input  cycle, in_valid, in_exception, in_interrupt, in_has_wdata,
        input  in_iaddr, in_cause, in_wdata, in_insn, in_priv,
        output out_cycle,
        output trace_0_valid, trace_0_exception, trace_0_interrupt,
        output trace_0_has_wdata, trace_0_iaddr, trace_0_cause,
        output trace_0_wdata, trace_0_insn, trace_0_priv,
        output trace_1_valid, trace_1_exception, trace_1_interrupt,
        output trace_1_has_wdata, trace_1_iaddr, trace_1_cause,
        output trace_1_wdata, trace_1_insn, trace_1_priv,
        output overflow, drop_count, empty
    );

endinterface

// File: rtl/trace_commit_compactor_lane_compact.sv
// Prefix count over a live-slot mask: per-slot packed offset and total.
module trace_lane_compact
    import trace_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]             live_i,
    output logic [LANES-1:0][LCNT_W-1:0] off_o,
    output logic [LCNT_W-1:0]            total_o
);

    logic [LCNT_W-1:0] acc;

    always_comb begin
        acc   = '0;
        off_o = '0;
        for (int k = 0; k < LANES; k++) begin
            off_o[k] = acc;
            acc      = acc + LCNT_W'(live_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/trace_commit_compactor.sv
// Packs a sparse multi-slot commit trace into an in-order FIFO and drains
// it two entries per cycle; overflow drops and latches instead of stalling.
module trace_commit_compactor
    import trace_pkg::*;
#(
    parameter int IN_LANES = 4,
    parameter int DEPTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    trace_commit_compactor_if.slave  bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [TRACE_ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count, free;
    state_e           state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_q, drop_d;

    logic [TRACE_ENTRY_W-1:0] lane0_q, lane0_d;
    logic [OFF_STAMP-1:0]     lane1_q, lane1_d;
    logic                     occ0_q, occ0_d;
    logic                     occ1_q, occ1_d;

    logic [IN_LANES-1:0]             live, wen;
    logic [IN_LANES-1:0][LCNT_W-1:0] off;
    logic [LCNT_W-1:0]               n_live, n_acc, n_drop;
    logic [AW-1:0]                   widx [IN_LANES];
    logic [TRACE_ENTRY_W-1:0]        ent_in [IN_LANES];
    logic [AW-1:0]                   ridx0, ridx1;
    logic [1:0]                      pop_n;

    assign live = bus.in_valid | bus.in_exception | bus.in_interrupt;

    trace_lane_compact #(.LANES(IN_LANES)) u_compact (
        .live_i  (live),
        .off_o   (off),
        .total_o (n_live)
    );

    always_comb begin
        for (int k = 0; k < IN_LANES; k++) begin
            ent_in[k] = '0;
            ent_in[k][OFF_STAMP +: XLEN]    = bus.cycle;
            ent_in[k][OFF_IADDR +: XLEN]    = bus.in_iaddr[k*XLEN +: XLEN];
            ent_in[k][OFF_CAUSE +: XLEN]    = bus.in_cause[k*XLEN +: XLEN];
            ent_in[k][OFF_WDATA +: XLEN]    = bus.in_wdata[k*XLEN +: XLEN];
            ent_in[k][OFF_INSN +: INSN_W]   = bus.in_insn[k*INSN_W +: INSN_W];
            ent_in[k][OFF_PRIV +: PRIV_W]   = bus.in_priv[k*PRIV_W +: PRIV_W];
            ent_in[k][OFF_VALID]            = bus.in_valid[k];
            ent_in[k][OFF_EXCEPTION]        = bus.in_exception[k];
            ent_in[k][OFF_INTERRUPT]        = bus.in_interrupt[k];
            ent_in[k][OFF_HAS_WDATA]        = bus.in_has_wdata[k];
        end
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign free  = PTR_W'(DEPTH) - count;

    // Only the oldest `free` live slots fit; pops this cycle do not help.
    always_comb begin
        wen   = '0;
        n_acc = '0;
        for (int k = 0; k < IN_LANES; k++) begin
            widx[k] = AW'(wr_ptr_q + PTR_W'(off[k]));
            wen[k]  = live[k] && (state_q == RUN) &&
                      (32'(off[k]) < 32'(free));
            n_acc   = n_acc + LCNT_W'(wen[k]);
        end
        n_drop = n_live - n_acc;
    end

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        unique case (state_q)
            RUN: begin
                if (n_drop != '0) begin
                    state_d    = FAULT;
                    overflow_d = 1'b1;
                end
            end
            FAULT: overflow_d = 1'b1;
        endcase
        drop_d = sat_add16(drop_q, n_drop);

        pop_n    = (count >= PTR_W'(2)) ? 2'd2 : count[1:0];
        wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);

        ridx0   = rd_ptr_q[AW-1:0];
        ridx1   = AW'(rd_ptr_q + PTR_W'(1));
        occ0_d  = (pop_n != 2'd0);
        occ1_d  = (pop_n == 2'd2);
        lane0_d = '0;
        lane1_d = '0;
        if (occ0_d) lane0_d = mem_q[ridx0];
        if (occ1_d) lane1_d = mem_q[ridx1][OFF_STAMP-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= RUN;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            lane0_q    <= '0;
            lane1_q    <= '0;
            occ0_q     <= 1'b0;
            occ1_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            lane0_q    <= lane0_d;
            lane1_q    <= lane1_d;
            occ0_q     <= occ0_d;
            occ1_q     <= occ1_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < IN_LANES; k++) begin
            if (wen[k]) mem_q[widx[k]] <= ent_in[k];
        end
    end

    assign bus.out_cycle         = lane0_q[OFF_STAMP +: XLEN];
    assign bus.trace_0_valid     = lane0_q[OFF_VALID];
    assign bus.trace_0_exception = lane0_q[OFF_EXCEPTION];
    assign bus.trace_0_interrupt = lane0_q[OFF_INTERRUPT];
    assign bus.trace_0_has_wdata = lane0_q[OFF_HAS_WDATA];
    assign bus.trace_0_iaddr     = lane0_q[OFF_IADDR +: XLEN];
    assign bus.trace_0_cause     = lane0_q[OFF_CAUSE +: XLEN];
    assign bus.trace_0_wdata     = lane0_q[OFF_WDATA +: XLEN];
    assign bus.trace_0_insn      = lane0_q[OFF_INSN +: INSN_W];
    assign bus.trace_0_priv      = lane0_q[OFF_PRIV +: PRIV_W];
    assign bus.trace_1_valid     = lane1_q[OFF_VALID];
    assign bus.trace_1_exception = lane1_q[OFF_EXCEPTION];
    assign bus.trace_1_interrupt = lane1_q[OFF_INTERRUPT];
    assign bus.trace_1_has_wdata = lane1_q[OFF_HAS_WDATA];
    assign bus.trace_1_iaddr     = lane1_q[OFF_IADDR +: XLEN];
    assign bus.trace_1_cause     = lane1_q[OFF_CAUSE +: XLEN];
    assign bus.trace_1_wdata     = lane1_q[OFF_WDATA +: XLEN];
    assign bus.trace_1_insn      = lane1_q[OFF_INSN +: INSN_W];
    assign bus.trace_1_priv      = lane1_q[OFF_PRIV +: PRIV_W];
    assign bus.overflow          = overflow_q;
    assign bus.drop_count        = drop_q;
    assign bus.empty             = (count == '0) & ~occ0_q & ~occ1_q;

endmodule

// File: tb/tb_trace_commit_compactor.sv
// Randomized bench for trace_commit_compactor against a queue-based model,
// plus directed cases with hand-computed expectations.
module tb_trace_commit_compactor;

    localparam int L = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_commit_compactor_if #(.IN_LANES(L)) bus();

    trace_commit_compactor #(.IN_LANES(L), .DEPTH(D)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] stamp, iaddr, cause, wdata;
        logic [31:0] insn;
        logic [2:0]  priv;
        logic        v, e, i, hw;
    } ent_t;

    ent_t q[$];
    ent_t x0, x1;
    bit   o0, o1, m_fault, chk_en;
    int   m_drop;
    int   tests = 0;
    int   fails = 0;

    function automatic ent_t zero_ent();
        ent_t z;
        z = '{default: '0};
        return z;
    endfunction

    function automatic logic [255:0] flat(input ent_t t);
        return 256'({t.iaddr, t.cause, t.wdata, t.insn, t.priv,
                     t.v, t.e, t.i, t.hw});
    endfunction

    function automatic logic [255:0] dut_lane0();
        return 256'({bus.trace_0_iaddr, bus.trace_0_cause, bus.trace_0_wdata,
                     bus.trace_0_insn, bus.trace_0_priv, bus.trace_0_valid,
                     bus.trace_0_exception, bus.trace_0_interrupt,
                     bus.trace_0_has_wdata});
    endfunction

    function automatic logic [255:0] dut_lane1();
        return 256'({bus.trace_1_iaddr, bus.trace_1_cause, bus.trace_1_wdata,
                     bus.trace_1_insn, bus.trace_1_priv, bus.trace_1_valid,
                     bus.trace_1_exception, bus.trace_1_interrupt,
                     bus.trace_1_has_wdata});
    endfunction

    function automatic ent_t slot_ent(input int k);
        ent_t t;
        t.stamp = bus.cycle;
        t.iaddr = bus.in_iaddr[64*k +: 64];
        t.cause = bus.in_cause[64*k +: 64];
        t.wdata = bus.in_wdata[64*k +: 64];
        t.insn  = bus.in_insn[32*k +: 32];
        t.priv  = bus.in_priv[3*k +: 3];
        t.v     = bus.in_valid[k];
        t.e     = bus.in_exception[k];
        t.i     = bus.in_interrupt[k];
        t.hw    = bus.in_has_wdata[k];
        return t;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference: FIFO as a queue; pop up to two, then accept in slot order
    // while start-of-cycle free space lasts and no fault has occurred.
    always @(posedge clk) begin
        int n, pop, fr, d;
        if (rst) begin
            q.delete();
            x0 = zero_ent();
            x1 = zero_ent();
            o0 = 0;
            o1 = 0;
            m_fault = 0;
            m_drop = 0;
            chk_en = 1;
        end else begin
            n   = q.size();
            pop = (n < 2) ? n : 2;
            fr  = D - n;
            d   = 0;
            x0  = zero_ent();
            x1  = zero_ent();
            o0  = (pop >= 1);
            o1  = (pop >= 2);
            if (o0) x0 = q.pop_front();
            if (o1) x1 = q.pop_front();
            for (int k = 0; k < L; k++) begin
                if (bus.in_valid[k] | bus.in_exception[k] | bus.in_interrupt[k]) begin
                    if (!m_fault && fr > 0) begin
                        q.push_back(slot_ent(k));
                        fr--;
                    end else begin
                        d++;
                    end
                end
            end
            if (d > 0) m_fault = 1;
            m_drop = (m_drop + d > 65535) ? 65535 : m_drop + d;
        end
    end

    always @(negedge clk) begin
        bit e_empty;
        if (chk_en) begin
            e_empty = (q.size() == 0) && !o0 && !o1;
            chk("lane0", dut_lane0(), flat(x0));
            chk("lane1", dut_lane1(), flat(x1));
            chk("out_cycle", 256'(bus.out_cycle), 256'(x0.stamp));
            chk("status", 256'({bus.overflow, bus.drop_count, bus.empty}),
                256'({m_fault, 16'(m_drop), e_empty}));
        end
    end

    task automatic clr();
        bus.in_valid     = '0;
        bus.in_exception = '0;
        bus.in_interrupt = '0;
        bus.in_has_wdata = '0;
        bus.in_iaddr     = '0;
        bus.in_cause     = '0;
        bus.in_wdata     = '0;
        bus.in_insn      = '0;
        bus.in_priv      = '0;
    endtask

    task automatic set_slot(input int k, input logic v, input logic e,
                            input logic [63:0] ia, input logic [63:0] ca,
                            input logic [31:0] ins);
        bus.in_valid[k]          = v;
        bus.in_exception[k]      = e;
        bus.in_interrupt[k]      = 1'b0;
        bus.in_has_wdata[k]      = 1'b1;
        bus.in_iaddr[64*k +: 64] = ia;
        bus.in_cause[64*k +: 64] = ca;
        bus.in_wdata[64*k +: 64] = ia ^ 64'h5a5a;
        bus.in_insn[32*k +: 32]  = ins;
        bus.in_priv[3*k +: 3]    = 3'd3;
    endtask

    task automatic rnd(input int dens);
        int kind;
        bit lv;
        bus.cycle = {$urandom, $urandom};
        for (int k = 0; k < L; k++) begin
            lv   = ($urandom_range(0, 99) < dens);
            kind = $urandom_range(0, 9);
            bus.in_valid[k]          = lv && (kind <= 7);
            bus.in_exception[k]      = lv && (kind == 7 || kind == 8);
            bus.in_interrupt[k]      = lv && (kind == 9);
            bus.in_has_wdata[k]      = 1'($urandom);
            bus.in_iaddr[64*k +: 64] = {$urandom, $urandom};
            bus.in_cause[64*k +: 64] = {$urandom, $urandom};
            bus.in_wdata[64*k +: 64] = {$urandom, $urandom};
            bus.in_insn[32*k +: 32]  = $urandom;
            bus.in_priv[3*k +: 3]    = 3'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rnd(100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr();
    endtask

    initial begin
        clr();
        bus.cycle = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_empty", 256'(bus.empty), 256'd1);
        chk("rst_drop", 256'(bus.drop_count), 256'd0);
        chk("rst_lane0", dut_lane0(), 256'd0);
        rst = 1'b0;

        // single entry in slot 2
        @(negedge clk);
        set_slot(2, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 32'h0000_0013);
        bus.cycle = 64'd100;
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("single_cycle", 256'(bus.out_cycle), 256'd100);
        chk("single_iaddr", 256'(bus.trace_0_iaddr), 256'h8000_0000);
        chk("single_insn", 256'(bus.trace_0_insn), 256'h13);
        chk("single_valid", 256'(bus.trace_0_valid), 256'd1);
        chk("single_lane1", dut_lane1(), 256'd0);

        // gapped burst: {0,3} then {1}
        @(negedge clk);
        set_slot(0, 1'b1, 1'b0, 64'h1000, 64'd0, 32'h1);
        set_slot(3, 1'b1, 1'b0, 64'h3000, 64'd0, 32'h3);
        @(negedge clk);
        clr();
        set_slot(1, 1'b1, 1'b0, 64'h2000, 64'd0, 32'h2);
        @(negedge clk);
        clr();
        chk("gap_t2_l0", 256'(bus.trace_0_iaddr), 256'h1000);
        chk("gap_t2_l1", 256'(bus.trace_1_iaddr), 256'h3000);
        @(negedge clk);
        chk("gap_t3_l0", 256'(bus.trace_0_iaddr), 256'h2000);
        chk("gap_t3_l1v", 256'(bus.trace_1_valid), 256'd0);

        // exception-only entry
        @(negedge clk);
        set_slot(1, 1'b0, 1'b1, 64'h4000, 64'd2, 32'h0);
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("exc_valid", 256'(bus.trace_0_valid), 256'd0);
        chk("exc_flag", 256'(bus.trace_0_exception), 256'd1);
        chk("exc_cause", 256'(bus.trace_0_cause), 256'd2);

        repeat (300) begin
            @(negedge clk);
            rnd(30);
        end
        @(negedge clk);
        clr();

        // reset mid-drain with six entries buffered
        do_reset();
        @(negedge clk);
        rnd(100);
        @(negedge clk);
        rnd(100);
        @(negedge clk);
        rst = 1'b1;
        rnd(100);
        @(negedge clk);
        chk("mid_rst_empty", 256'(bus.empty), 256'd1);
        chk("mid_rst_lane0", dut_lane0(), 256'd0);
        chk("mid_rst_cycle", 256'(bus.out_cycle), 256'd0);
        rst = 1'b0;
        clr();
        set_slot(0, 1'b1, 1'b0, 64'h5000, 64'd0, 32'h5);
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("post_rst_iaddr", 256'(bus.trace_0_iaddr), 256'h5000);

        // sustained load: first drops happen on the 7th busy cycle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 6) chk("sus_no_ovf", 256'(bus.overflow), 256'd0);
            if (i == 7) chk("sus_ovf", 256'(bus.overflow), 256'd1);
            rnd(100);
        end
        @(negedge clk);
        clr();
        chk("sus_drops", 256'(bus.drop_count), 256'd6);
        repeat (10) @(negedge clk);
        chk("sus_empty", 256'(bus.empty), 256'd1);

        repeat (200) begin
            @(negedge clk);
            rnd(60);
        end

        // saturation of the drop counter
        @(negedge clk);
        clr();
        bus.in_valid = '1;
        repeat (17500) @(negedge clk);
        chk("sat_drop", 256'(bus.drop_count), 256'hFFFF);
        clr();

        do_reset();
        repeat (400) begin
            @(negedge clk);
            rnd(40);
        end
        @(negedge clk);
        clr();
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
